// File: rtl/mon_pkg.sv
// mon_pkg: opcodes, reply words and FSM encoding shared by the monitor command engine.
package mon_pkg;

    localparam int MON_WORD_W = 32;

    localparam logic [7:0] MON_OP_READ  = 8'h01;
    localparam logic [7:0] MON_OP_WRITE = 8'h02;
    localparam logic [7:0] MON_OP_PING  = 8'h03;

    localparam logic [MON_WORD_W-1:0] MON_RSP_WACK   = 32'h0000_00A5;
    localparam logic [MON_WORD_W-1:0] MON_RSP_PING   = 32'h4D4F_4E31;
    localparam logic [15:0]           MON_ERR_PREFIX = 16'hEEEE;
    localparam logic [7:0]            MON_ERR_UNKNOWN = 8'h00;
    localparam logic [7:0]            MON_ERR_TIMEOUT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS,
        ST_RESP
    } mon_state_e;

    function automatic logic [MON_WORD_W-1:0] mon_err_word(input logic [7:0] code, input logic [7:0] op);
        return {MON_ERR_PREFIX, code, op};
    endfunction

endpackage

// File: rtl/monitor_cmd_engine_if.sv
// monitor_cmd_engine_if: rx/tx word streams and debug-bus signals of the monitor command engine.
interface monitor_cmd_engine_if #(parameter int W = 32) ();

    logic         rx_valid_i;
    logic         rx_ready_o;
    logic [W-1:0] rx_data_i;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic [W-1:0] tx_data_o;
    logic         bus_req_o;
    logic         bus_we_o;
    logic [W-1:0] bus_addr_o;
    logic [W-1:0] bus_wdata_o;
    logic [W-1:0] bus_rdata_i;
    logic         bus_ack_i;

    modport master (
        input  rx_valid_i, rx_data_i, tx_ready_i, bus_rdata_i, bus_ack_i,
        output rx_ready_o, tx_valid_o, tx_data_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, tx_ready_i, bus_rdata_i, bus_ack_i,
        input  rx_ready_o, tx_valid_o, tx_data_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

endinterface

// File: rtl/mon_timeout_cnt.sv
// mon_timeout_cnt: 16-bit bus-cycle counter flagging the last allowed cycle of a transaction.
module mon_timeout_cnt #(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (en_i ? cnt_q + 16'd1 : cnt_q);

    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;

    assign expire_o = cnt_q == 16'(LIMIT - 1);

endmodule

// File: rtl/monitor_cmd_engine.sv
// monitor_cmd_engine: UART word-stream command responder doing single debug-bus peek/poke.
// Define MON_CMD_TIMEOUT_EN to abort bus transactions after TIMEOUT_CYC cycles.
module monitor_cmd_engine
    import mon_pkg::*;
#(
    parameter int WORD_W      = MON_WORD_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    monitor_cmd_engine_if.master io,
    output logic                 busy_o
);

    if (WORD_W != MON_WORD_W || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("monitor_cmd_engine: unsupported WORD_W or TIMEOUT_CYC");
    end

    mon_state_e        state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] bus_addr_q, bus_addr_d;
    logic [WORD_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_we_q, bus_we_d;
    logic [WORD_W-1:0] tx_data_q, tx_data_d;
    logic              rx_hs, to_exp;
    logic [7:0]        hdr_op;

    assign hdr_op = io.rx_data_i[7:0];
    assign rx_hs  = io.rx_valid_i && io.rx_ready_o;

`ifdef MON_CMD_TIMEOUT_EN
    mon_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q != ST_BUS),
        .en_i     (state_q == ST_BUS && !io.bus_ack_i),
        .expire_o (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // Bus-facing registers load only on BUS entry so they hold steady outside BUS.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        tx_data_d   = tx_data_q;
        case (state_q)
            ST_IDLE: if (rx_hs) begin
                op_d = hdr_op;
                if (hdr_op == MON_OP_READ || hdr_op == MON_OP_WRITE) begin
                    state_d = ST_GET_ADDR;
                end else begin
                    state_d   = ST_RESP;
                    tx_data_d = (hdr_op == MON_OP_PING) ? MON_RSP_PING : mon_err_word(MON_ERR_UNKNOWN, hdr_op);
                end
            end
            ST_GET_ADDR: if (rx_hs) begin
                addr_d = io.rx_data_i;
                if (op_q == MON_OP_WRITE) begin
                    state_d = ST_GET_DATA;
                end else begin
                    state_d    = ST_BUS;
                    bus_addr_d = io.rx_data_i;
                    bus_we_d   = 1'b0;
                end
            end
            ST_GET_DATA: if (rx_hs) begin
                state_d     = ST_BUS;
                bus_addr_d  = addr_q;
                bus_we_d    = 1'b1;
                bus_wdata_d = io.rx_data_i;
            end
            ST_BUS: if (io.bus_ack_i) begin
                state_d   = ST_RESP;
                tx_data_d = bus_we_q ? MON_RSP_WACK : io.bus_rdata_i;
            end else if (to_exp) begin
                state_d   = ST_RESP;
                tx_data_d = mon_err_word(MON_ERR_TIMEOUT, op_q);
            end
            ST_RESP: if (io.tx_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are gated by reset so nothing is offered while it is asserted.
    always_comb begin
        io.rx_ready_o  = !rst_i && (state_q == ST_IDLE || state_q == ST_GET_ADDR || state_q == ST_GET_DATA);
        io.bus_req_o   = !rst_i && state_q == ST_BUS;
        io.tx_valid_o  = !rst_i && state_q == ST_RESP;
        busy_o         = !rst_i && state_q != ST_IDLE;
        io.tx_data_o   = tx_data_q;
        io.bus_addr_o  = bus_addr_q;
        io.bus_we_o    = bus_we_q;
        io.bus_wdata_o = bus_wdata_q;
    end

endmodule

// File: tb/tb_monitor_cmd_engine.sv
// tb_monitor_cmd_engine: directed and randomized checks of monitor_cmd_engine against a transaction-level model.
module tb_monitor_cmd_engine;
    import mon_pkg::*;

`ifdef MON_CMD_TIMEOUT_EN
    localparam int TO = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0, bus_ack = 1'b0, tx_ready = 1'b0;
    logic [31:0] rx_data = '0, bus_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    monitor_cmd_engine_if #(.W(32)) io ();
    assign io.rx_valid_i  = rx_valid;
    assign io.rx_data_i   = rx_data;
    assign io.bus_ack_i   = bus_ack;
    assign io.bus_rdata_i = bus_rdata;
    assign io.tx_ready_i  = tx_ready;

    monitor_cmd_engine #(.WORD_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .io     (io),
        .busy_o (busy)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: words still owed by the current command, a pending bus
    // transaction with its elapsed cycles, and a pending reply.
    logic [31:0] src_q[$];
    int          m_need = 0, m_got = 0, m_cyc = 0, m_nrep = 0;
    bit          m_bus = 0, m_resp = 0, m_acc = 0, m_we = 0;
    logic [7:0]  m_op = '0;
    logic [31:0] m_a = '0, m_d = '0, m_txd = '0, m_addr = '0, m_wdata = '0;

    function automatic bit m_busy();
        return m_need != 0 || m_bus || m_resp;
    endfunction

    always @(posedge clk) begin
        m_acc = 1'b0;
        if (rst) begin
            m_need = 0; m_got = 0; m_cyc = 0; m_bus = 0; m_resp = 0; m_we = 0;
            m_op = '0; m_txd = '0; m_addr = '0; m_wdata = '0;
        end else if (m_resp) begin
            if (tx_ready) begin
                m_resp = 0;
                m_nrep++;
            end
        end else if (m_bus) begin
            if (bus_ack) begin
                m_bus = 0; m_resp = 1;
                m_txd = m_we ? 32'h0000_00A5 : bus_rdata;
            end else if (TO_EN && m_cyc == TO - 1) begin
                m_bus = 0; m_resp = 1;
                m_txd = {16'hEEEE, 8'hFF, m_op};
            end else begin
                m_cyc++;
            end
        end else if (rx_valid) begin
            m_acc = 1'b1;
            if (src_q.size() > 0) void'(src_q.pop_front());
            if (m_need == 0) begin
                m_op   = rx_data[7:0];
                m_need = (m_op == 8'h01) ? 1 : (m_op == 8'h02) ? 2 : 0;
                m_got  = 0;
                if (m_need == 0) begin
                    m_resp = 1;
                    m_txd  = (m_op == 8'h03) ? 32'h4D4F_4E31 : {16'hEEEE, 8'h00, m_op};
                end
            end else begin
                if (m_got == 0) m_a = rx_data;
                else m_d = rx_data;
                m_got++;
                if (m_got == m_need) begin
                    m_need = 0; m_bus = 1; m_cyc = 0;
                    m_addr = m_a;
                    m_we   = (m_op == 8'h02);
                    if (m_we) m_wdata = m_d;
                end
            end
        end
    end

    int          rx_pct = 100, ack_mode = 1, ack_dly = 3, tx_mode = 1;
    bit          rd_fix = 1'b0;
    logic [31:0] rd_val = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!(rx_valid && !m_acc)) begin
                rx_valid = src_q.size() > 0 && ($urandom_range(0, 99) < rx_pct);
                rx_data  = rx_valid ? src_q[0] : $urandom;
            end
            bus_rdata = rd_fix ? rd_val : $urandom;
            bus_ack   = (ack_mode == 0) ? ($urandom_range(0, 3) == 0) :
                        (ack_mode == 1) ? (m_bus && m_cyc == ack_dly - 1) : 1'b0;
            tx_ready  = (tx_mode == 0) ? 1'($urandom_range(0, 1)) : (tx_mode == 1);
        end
    end

    int          req_cnt = 0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic        cap_we = 1'b0;
    logic [31:0] dut_reps[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_ready", io.rx_ready_o, !rst && !m_bus && !m_resp);
            chk("tx_valid", io.tx_valid_o, !rst && m_resp);
            chk("bus_req", io.bus_req_o, !rst && m_bus);
            chk("busy", busy, !rst && m_busy());
            chk("tx_data", io.tx_data_o, m_txd);
            chk("bus_addr", io.bus_addr_o, m_addr);
            chk("bus_we", io.bus_we_o, m_we);
            chk("bus_wdata", io.bus_wdata_o, m_wdata);
            if (io.bus_req_o === 1'b1) begin
                req_cnt++;
                cap_addr  = io.bus_addr_o;
                cap_we    = io.bus_we_o;
                cap_wdata = io.bus_wdata_o;
            end
            if (!rst && io.tx_valid_o === 1'b1 && tx_ready) dut_reps.push_back(io.tx_data_o);
        end
    end

    task automatic send(input logic [31:0] w);
        src_q.push_back(w);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((src_q.size() != 0 || rx_valid || m_busy()) && n < budget);
        checks++;
        if (src_q.size() != 0 || rx_valid || m_busy()) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, required finish");
        summary();
        $finish;
    end

    int         n0;
    int         k;
    logic [7:0] op;

    initial begin
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("lit_rst_rx_ready", io.rx_ready_o, 32'd0);
        chk("lit_rst_tx_data", io.tx_data_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("lit_post_rst_rx_ready", io.rx_ready_o, 32'd1);

        n0 = dut_reps.size();
        send(32'h0000_0003);
        wait_idle(100);
        chk("lit_ping_count", dut_reps.size(), n0 + 1);
        chk("lit_ping_reply", dut_reps[$], 32'h4D4F_4E31);
        chk("lit_ping_busy", busy, 32'd0);

        rd_fix = 1'b1; rd_val = 32'hDEAD_BEEF; req_cnt = 0;
        send(32'h0000_0001); send(32'h0000_1000);
        wait_idle(100);
        chk("lit_read_req_cycles", req_cnt, 32'd3);
        chk("lit_read_we", cap_we, 32'd0);
        chk("lit_read_addr", cap_addr, 32'h0000_1000);
        chk("lit_read_reply", dut_reps[$], 32'hDEAD_BEEF);

        req_cnt = 0;
        send(32'h0000_0002); send(32'h0000_2004); send(32'h1234_5678);
        wait_idle(100);
        chk("lit_write_we", cap_we, 32'd1);
        chk("lit_write_addr", cap_addr, 32'h0000_2004);
        chk("lit_write_data", cap_wdata, 32'h1234_5678);
        chk("lit_write_reply", dut_reps[$], 32'h0000_00A5);

        req_cnt = 0;
        send(32'h0000_007F);
        wait_idle(100);
        chk("lit_unknown_reply", dut_reps[$], 32'hEEEE_007F);
        chk("lit_unknown_no_req", req_cnt, 32'd0);

`ifdef MON_CMD_TIMEOUT_EN
        ack_mode = 2; req_cnt = 0;
        send(32'h0000_0001); send(32'h0000_0040);
        wait_idle(100);
        chk("lit_timeout_req_cycles", req_cnt, 32'd8);
        chk("lit_timeout_reply", dut_reps[$], 32'hEEEE_FF01);
`endif

        ack_mode = 2; tx_mode = 2;
        n0 = dut_reps.size();
        send(32'h0000_0001); send(32'h0000_3000);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("lit_midrst_req", io.bus_req_o, 32'd0);
        chk("lit_midrst_tx_valid", io.tx_valid_o, 32'd0);
        chk("lit_midrst_busy", busy, 32'd0);
        chk("lit_midrst_rx_ready", io.rx_ready_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lit_midrst_tx_data", io.tx_data_o, 32'd0);
        chk("lit_midrst_addr", io.bus_addr_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ack_mode = 1; tx_mode = 1;
        repeat (5) @(posedge clk);
        chk("lit_midrst_no_reply", dut_reps.size(), n0);
        send(32'h0000_0003);
        wait_idle(100);
        chk("lit_midrst_ping", dut_reps[$], 32'h4D4F_4E31);

        rx_pct = 70; ack_mode = 0; tx_mode = 0; rd_fix = 1'b0;
        for (int b = 0; b < 40; b++) begin
            for (int c = 0; c < 4; c++) begin
                k  = $urandom_range(0, 3);
                op = (k == 0) ? 8'h01 : (k == 1) ? 8'h02 : (k == 2) ? 8'h03 : 8'($urandom);
                send(($urandom & 32'hFFFF_FF00) | {24'd0, op});
                if (op == 8'h01 || op == 8'h02) send($urandom);
                if (op == 8'h02) send($urandom);
            end
            wait_idle(3000);
        end

        @(negedge clk);
        chk("reply_count", dut_reps.size(), m_nrep);
        summary();
        $finish;
    end

endmodule
